// File: rtl/fpga_io_pkg.sv
// Shared types and constants for the board input conditioning front end.
// Key roles, switch/word widths and the reset-sequencer state encoding.
package fpga_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_HOLD
  } rst_state_t;

  localparam int KEY_RST  = 0;
  localparam int KEY_STEP = 1;
  localparam int KEY_MODE = 2;
  localparam int KEY_LOAD = 3;

  localparam int SW_W   = 10;
  localparam int WORD_W = 16;

  function automatic logic [WORD_W-1:0] sign_extend(input logic [SW_W-1:0] sw);
    return {{(WORD_W - SW_W){sw[SW_W-1]}}, sw};
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// One push-button channel: two-flop synchronizer, stability counter and a
// registered single-cycle pulse when the debounced level goes pressed (1->0).
module key_debouncer
  import fpga_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic stable,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync_meta;
  logic          sync_key;
  logic          stable_prev;
  logic [CW-1:0] cnt;

  // The counter never holds DEBOUNCE_CYCLES itself: the cycle that would
  // reach it commits the new level and clears instead.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_meta   <= 1'b1;
      sync_key    <= 1'b1;
      stable      <= 1'b1;
      stable_prev <= 1'b1;
      press       <= 1'b0;
      cnt         <= '0;
    end else begin
      sync_meta   <= key;
      sync_key    <= sync_meta;
      stable_prev <= stable;
      press       <= stable_prev & ~stable;
      if (sync_key != stable) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable <= sync_key;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/fpga_input_conditioner.sv
// Board KEY/SW conditioning for cpu_16bit: stretched CPU reset, run/step
// clock enable and the latched sign-extended initial_input word.
module fpga_input_conditioner
  import fpga_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RESET_HOLD      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        KEY,
  input  logic [SW_W-1:0]   SW,
  output logic              cpu_reset,
  output logic              cpu_clk_en,
  output logic              run_mode,
  output logic [WORD_W-1:0] initial_input,
  output logic [3:0]        key_pressed
);

  localparam int HW = $clog2(RESET_HOLD + 1);

  logic [3:0]      stable;
  logic [3:0]      press;
  rst_state_t      state;
  logic [HW-1:0]   hold_cnt;
  logic [SW_W-1:0] sw_meta;
  logic [SW_W-1:0] sw_sync;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk   (clk),
      .rst_n (rst_n),
      .key   (KEY[i]),
      .stable(stable[i]),
      .press (press[i])
    );
  end

  assign key_pressed = ~stable;

  // cpu_reset is registered alongside the state so it reflects the state
  // being entered; HOLD leaves on the edge where the count already reads 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_HOLD;
      hold_cnt  <= HW'(RESET_HOLD);
      cpu_reset <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (key_pressed[KEY_RST]) begin
            state     <= ST_PRESS;
            cpu_reset <= 1'b1;
          end else begin
            cpu_reset <= 1'b0;
          end
        end
        ST_PRESS: begin
          cpu_reset <= 1'b1;
          if (!key_pressed[KEY_RST]) begin
            state    <= ST_HOLD;
            hold_cnt <= HW'(RESET_HOLD);
          end
        end
        ST_HOLD: begin
          if (key_pressed[KEY_RST]) begin
            state     <= ST_PRESS;
            cpu_reset <= 1'b1;
          end else if (hold_cnt == HW'(1)) begin
            state     <= ST_IDLE;
            cpu_reset <= 1'b0;
          end else begin
            hold_cnt  <= hold_cnt - HW'(1);
            cpu_reset <= 1'b1;
          end
        end
        default: begin
          state     <= ST_HOLD;
          hold_cnt  <= HW'(RESET_HOLD);
          cpu_reset <= 1'b1;
        end
      endcase
    end
  end

  // A step reads the pre-toggle run_mode; key events are dropped in reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_mode   <= 1'b1;
      cpu_clk_en <= 1'b0;
    end else begin
      if (!cpu_reset && press[KEY_MODE]) begin
        run_mode <= ~run_mode;
      end
      cpu_clk_en <= !cpu_reset && (run_mode || press[KEY_STEP]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_meta       <= '0;
      sw_sync       <= '0;
      initial_input <= '0;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
      if (cpu_reset || press[KEY_LOAD]) begin
        initial_input <= sign_extend(sw_sync);
      end
    end
  end

endmodule

// File: tb/tb_fpga_input_conditioner.sv
// Scoreboard bench for fpga_input_conditioner with short debounce/hold:
// expectations are queued with their due cycle and checked at the falling edge.
module tb_fpga_input_conditioner;

  logic        clk;
  logic        rst_n;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic        cpu_reset;
  logic        cpu_clk_en;
  logic        run_mode;
  logic [15:0] initial_input;
  logic [3:0]  key_pressed;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int base;

  int          sbCyc[$];
  int          sbSel[$];
  logic [15:0] sbVal[$];
  string       sbTag[$];

  localparam int SEL_RST = 0;
  localparam int SEL_EN  = 1;
  localparam int SEL_RUN = 2;
  localparam int SEL_IN  = 3;
  localparam int SEL_KP  = 4;

  fpga_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .RESET_HOLD     (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .KEY          (KEY),
    .SW           (SW),
    .cpu_reset    (cpu_reset),
    .cpu_clk_en   (cpu_clk_en),
    .run_mode     (run_mode),
    .initial_input(initial_input),
    .key_pressed  (key_pressed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Compare one observed value against its expectation and count it.
  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%04h, want 0x%04h", tag, cyc, observed, expected);
    end
  endtask

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      SEL_RST: return {15'd0, cpu_reset};
      SEL_EN:  return {15'd0, cpu_clk_en};
      SEL_RUN: return {15'd0, run_mode};
      SEL_IN:  return initial_input;
      default: return {12'd0, key_pressed};
    endcase
  endfunction

  // Queue an expectation due `off` edges after the current cycle.
  task automatic expectAt(input int off, input string tag, input int sel, input logic [15:0] val);
    sbCyc.push_back(cyc + off);
    sbTag.push_back(tag);
    sbSel.push_back(sel);
    sbVal.push_back(val);
  endtask

  // Drive inputs at a falling edge so the next rising edge samples them.
  task automatic applyStimulus(input logic r, input logic [3:0] k, input logic [9:0] s);
    @(negedge clk);
    rst_n = r;
    KEY   = k;
    SW    = s;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int i = sbCyc.size() - 1; i >= 0; i--) begin
      if (sbCyc[i] <= cyc) begin
        if (sbCyc[i] == cyc) begin
          checkOutput(sbTag[i], observe(sbSel[i]), sbVal[i]);
        end else begin
          checks++;
          errors++;
          $display("[TB] FAIL %s late: due %0d, now %0d", sbTag[i], sbCyc[i], cyc);
        end
        sbCyc.delete(i);
        sbTag.delete(i);
        sbSel.delete(i);
        sbVal.delete(i);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    KEY   = 4'hF;
    SW    = 10'h0AB;

    $display("[TB] power-on reset");
    expectAt(3, "por_rst", SEL_RST, 16'd1);
    expectAt(3, "por_en", SEL_EN, 16'd0);
    expectAt(3, "por_run", SEL_RUN, 16'd1);
    expectAt(3, "por_in", SEL_IN, 16'h0000);
    expectAt(3, "por_kp", SEL_KP, 16'h0000);
    waitCycles(5);
    rst_n = 1'b1;
    expectAt(2, "hold_rst", SEL_RST, 16'd1);
    expectAt(3, "hold_rst_end", SEL_RST, 16'd0);
    expectAt(3, "hold_en", SEL_EN, 16'd0);
    expectAt(3, "hold_in", SEL_IN, 16'h00AB);
    expectAt(4, "run_en", SEL_EN, 16'd1);
    expectAt(4, "run_mode", SEL_RUN, 16'd1);
    waitCycles(6);

    $display("[TB] bounce rejection on KEY[2]");
    for (int n = 0; n < 5; n++) begin
      applyStimulus(1'b1, 4'b1011, 10'h0AB);
      expectAt(2, "bounce_kp", SEL_KP, 16'h0000);
      expectAt(3, "bounce_run", SEL_RUN, 16'd1);
      expectAt(3, "bounce_en", SEL_EN, 16'd1);
      waitCycles(1);
      applyStimulus(1'b1, 4'b1111, 10'h0AB);
      waitCycles(1);
    end
    expectAt(8, "bounce_kp_after", SEL_KP, 16'h0000);
    expectAt(8, "bounce_run_after", SEL_RUN, 16'd1);
    waitCycles(9);

    $display("[TB] switch to single-step");
    applyStimulus(1'b1, 4'b1011, 10'h0AB);
    expectAt(5, "mode_kp_pre", SEL_KP, 16'h0000);
    expectAt(6, "mode_kp", SEL_KP, 16'h0004);
    expectAt(7, "mode_run_pre", SEL_RUN, 16'd1);
    expectAt(8, "mode_run", SEL_RUN, 16'd0);
    expectAt(8, "mode_en_pre", SEL_EN, 16'd1);
    expectAt(9, "mode_en", SEL_EN, 16'd0);
    waitCycles(9);
    applyStimulus(1'b1, 4'b1111, 10'h0AB);
    expectAt(12, "mode_run_rel", SEL_RUN, 16'd0);
    waitCycles(13);

    for (int p = 0; p < 2; p++) begin
      $display("[TB] single-step press %0d", p);
      applyStimulus(1'b1, 4'b1101, 10'h0AB);
      for (int off = 1; off <= 20; off++) begin
        expectAt(off, "step_en", SEL_EN, (off == 8) ? 16'd1 : 16'd0);
      end
      waitCycles(9);
      applyStimulus(1'b1, 4'b1111, 10'h0AB);
      waitCycles(11);
    end

    $display("[TB] load word");
    applyStimulus(1'b1, 4'b0111, 10'h200);
    expectAt(7, "load_pre", SEL_IN, 16'h00AB);
    expectAt(8, "load_neg", SEL_IN, 16'hFE00);
    waitCycles(9);
    applyStimulus(1'b1, 4'b1111, 10'h200);
    waitCycles(5);
    applyStimulus(1'b1, 4'b1111, 10'h1FF);
    expectAt(6, "load_hold", SEL_IN, 16'hFE00);
    waitCycles(7);

    $display("[TB] reset key press");
    applyStimulus(1'b1, 4'b1110, 10'h1FF);
    expectAt(6, "key_rst_kp", SEL_KP, 16'h0001);
    expectAt(6, "key_rst_pre", SEL_RST, 16'd0);
    expectAt(7, "key_rst", SEL_RST, 16'd1);
    expectAt(7, "key_rst_in_pre", SEL_IN, 16'hFE00);
    expectAt(8, "key_rst_in", SEL_IN, 16'h01FF);
    expectAt(8, "key_rst_en", SEL_EN, 16'd0);
    waitCycles(9);
    applyStimulus(1'b1, 4'b1111, 10'h1FF);
    expectAt(9, "key_hold_rst", SEL_RST, 16'd1);
    expectAt(10, "key_hold_end", SEL_RST, 16'd0);
    expectAt(11, "key_hold_en", SEL_EN, 16'd0);
    waitCycles(12);

    $display("[TB] reset dominance over mode key");
    applyStimulus(1'b1, 4'b1010, 10'h1FF);
    expectAt(6, "dom_kp", SEL_KP, 16'h0005);
    expectAt(7, "dom_rst", SEL_RST, 16'd1);
    expectAt(8, "dom_run", SEL_RUN, 16'd0);
    for (int off = 1; off <= 12; off++) begin
      expectAt(off, "dom_en", SEL_EN, 16'd0);
    end
    waitCycles(9);
    applyStimulus(1'b1, 4'b1111, 10'h1FF);
    expectAt(4, "dom_run_mid", SEL_RUN, 16'd0);
    expectAt(9, "dom_rst_hold", SEL_RST, 16'd1);
    expectAt(10, "dom_rst_end", SEL_RST, 16'd0);
    expectAt(12, "dom_run_end", SEL_RUN, 16'd0);
    expectAt(12, "dom_en_end", SEL_EN, 16'd0);
    waitCycles(13);

    $display("[TB] rst_n during hold");
    applyStimulus(1'b0, 4'b1111, 10'h1FF);
    base = cyc;
    applyStimulus(1'b1, 4'b1111, 10'h1FF);
    applyStimulus(1'b0, 4'b1111, 10'h1FF);
    applyStimulus(1'b0, 4'b1111, 10'h1FF);
    applyStimulus(1'b1, 4'b1111, 10'h1FF);
    expectAt(base + 5 - cyc, "mid_run", SEL_RUN, 16'd1);
    expectAt(base + 5 - cyc, "mid_rst_a", SEL_RST, 16'd1);
    expectAt(base + 6 - cyc, "mid_rst_b", SEL_RST, 16'd1);
    expectAt(base + 6 - cyc, "mid_in_zero", SEL_IN, 16'h0000);
    expectAt(base + 7 - cyc, "mid_rst_end", SEL_RST, 16'd0);
    expectAt(base + 7 - cyc, "mid_in", SEL_IN, 16'h01FF);
    expectAt(base + 7 - cyc, "mid_en_pre", SEL_EN, 16'd0);
    expectAt(base + 8 - cyc, "mid_en", SEL_EN, 16'd1);
    waitCycles(10);

    if (sbCyc.size() != 0) begin
      errors += sbCyc.size();
      checks += sbCyc.size();
      $display("[TB] FAIL scoreboard: %0d expectations never reached, want 0", sbCyc.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
